// File: rtl/cache_sa_wb_lru_if.sv
// CPU-side and memory-side signal bundle for the set-associative write-back cache.
// The cache takes the slave modport; the CPU/memory environment takes master.
interface cache_sa_wb_lru_if #(
  parameter int unsigned c_line_size  = 32,
  parameter int unsigned address_size = 32,
  parameter int unsigned c_block_size = 2
);
  localparam int unsigned LineW    = (2 ** c_block_size) * c_line_size;
  localparam int unsigned MemAddrW = address_size - c_block_size - 2;

  logic [address_size-1:0]  address_i;
  logic                     c_read_i;
  logic                     c_wr_i;
  logic [c_line_size-1:0]   c_write_data_i;
  logic [c_line_size/8-1:0] c_byte_en_i;
  logic                     c_flush_i;
  logic [c_line_size-1:0]   c_data_o;
  logic                     c_busywait_o;
  logic                     c_flush_done_o;
  logic                     c_hit_o;
  logic                     c_miss_o;
  logic                     c_m_read_o;
  logic                     c_m_wr_o;
  logic [MemAddrW-1:0]      c_m_address_o;
  logic [LineW-1:0]         c_m_write_data_o;
  logic [LineW-1:0]         c_m_read_data_i;
  logic                     c_m_busywait_i;
  logic                     m_read_done;
  logic                     m_write_done;

  modport slave (
    input  address_i, c_read_i, c_wr_i, c_write_data_i, c_byte_en_i, c_flush_i,
    input  c_m_read_data_i, c_m_busywait_i, m_read_done, m_write_done,
    output c_data_o, c_busywait_o, c_flush_done_o, c_hit_o, c_miss_o,
    output c_m_read_o, c_m_wr_o, c_m_address_o, c_m_write_data_o
  );

  modport master (
    output address_i, c_read_i, c_wr_i, c_write_data_i, c_byte_en_i, c_flush_i,
    output c_m_read_data_i, c_m_busywait_i, m_read_done, m_write_done,
    input  c_data_o, c_busywait_o, c_flush_done_o, c_hit_o, c_miss_o,
    input  c_m_read_o, c_m_wr_o, c_m_address_o, c_m_write_data_o
  );
endinterface

// File: rtl/cache_sa_wb_lru.sv
// Set-associative write-back/write-allocate data cache with true LRU (age counters),
// byte-enable writes, full-cache flush and hit/miss event pulses.
module cache_sa_wb_lru #(
  parameter int unsigned c_line_size   = 32,
  parameter int unsigned address_size  = 32,
  parameter int unsigned c_assiotivity = 2,
  parameter int unsigned c_index       = 2,
  parameter int unsigned c_block_size  = 2
) (
  input logic             clk_i,
  input logic             reset_i,
  cache_sa_wb_lru_if.slave bus
);
  localparam int unsigned Ways  = 2 ** c_assiotivity;
  localparam int unsigned Sets  = 2 ** c_index;
  localparam int unsigned Words = 2 ** c_block_size;
  localparam int unsigned Bytes = c_line_size / 8;
  localparam int unsigned TagW  = address_size - c_index - c_block_size - 2;
  localparam int unsigned PtrW  = c_index + c_assiotivity;

  typedef enum logic [2:0] {
    StIdle, StWriteBack, StFill, StFillDone, StFlushScan, StFlushWb
  } state_e;

  state_e state_q, state_d;

  logic [Sets-1:0][Ways-1:0]             valid_q, dirty_q;
  logic [TagW-1:0]                       tag_q  [Sets][Ways];
  logic [Words-1:0][c_line_size-1:0]     data_q [Sets][Ways];
  logic [c_assiotivity-1:0]              age_q  [Sets][Ways];
  logic [c_assiotivity-1:0]              victim_q;
  logic [PtrW-1:0]                       fptr_q;
  logic                                  flush_done_q;

  logic [c_block_size-1:0]  off;
  logic [c_index-1:0]       idx, fidx;
  logic [TagW-1:0]          tag;
  logic [c_assiotivity-1:0] hit_way, victim, inv_way, lru_way, upd_way, fway;
  logic                     req, hit, inv_found, rd_ok, wb_ok, flush_go, upd_en;
  logic                     unused_addr;

  assign off         = bus.address_i[c_block_size+1:2];
  assign idx         = bus.address_i[c_block_size+c_index+1:c_block_size+2];
  assign tag         = bus.address_i[address_size-1 -: TagW];
  assign unused_addr = ^bus.address_i[1:0];
  // Flush pointer is index-major: set in the upper bits, way in the lower bits.
  assign fidx        = fptr_q[PtrW-1 -: c_index];
  assign fway        = fptr_q[c_assiotivity-1:0];
  assign req         = bus.c_read_i | bus.c_wr_i;
  assign rd_ok       = bus.m_read_done & ~bus.c_m_busywait_i;
  assign wb_ok       = bus.m_write_done & ~bus.c_m_busywait_i;
  assign flush_go    = (state_q == StIdle) & ~req & bus.c_flush_i;

  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    lru_way   = '0;
    for (int w = 0; w < Ways; w++) begin
      if (valid_q[idx][w] && tag_q[idx][w] == tag) begin
        hit     = 1'b1;
        hit_way = c_assiotivity'(w);
      end
      if (!valid_q[idx][w] && !inv_found) begin
        inv_found = 1'b1;
        inv_way   = c_assiotivity'(w);
      end
      if (age_q[idx][w] == c_assiotivity'(Ways - 1)) lru_way = c_assiotivity'(w);
    end
    victim = inv_found ? inv_way : lru_way;
  end

  always_comb begin
    state_d              = state_q;
    upd_en               = 1'b0;
    upd_way              = hit_way;
    bus.c_data_o         = '0;
    bus.c_busywait_o     = 1'b0;
    bus.c_hit_o          = 1'b0;
    bus.c_miss_o         = 1'b0;
    bus.c_m_read_o       = 1'b0;
    bus.c_m_wr_o         = 1'b0;
    bus.c_m_address_o    = '0;
    bus.c_m_write_data_o = '0;
    bus.c_flush_done_o   = flush_done_q;
    unique case (state_q)
      StIdle: begin
        if (req && hit) begin
          bus.c_hit_o  = 1'b1;
          bus.c_data_o = data_q[idx][hit_way][off];
          upd_en       = 1'b1;
        end else if (req) begin
          bus.c_busywait_o = 1'b1;
          bus.c_miss_o     = 1'b1;
          state_d          = dirty_q[idx][victim] ? StWriteBack : StFill;
        end else if (bus.c_flush_i) begin
          state_d = StFlushScan;
        end
      end
      StWriteBack: begin
        bus.c_busywait_o     = 1'b1;
        bus.c_m_wr_o         = 1'b1;
        bus.c_m_address_o    = {tag_q[idx][victim_q], idx};
        bus.c_m_write_data_o = data_q[idx][victim_q];
        if (wb_ok) state_d = StFill;
      end
      StFill: begin
        bus.c_busywait_o  = 1'b1;
        bus.c_m_read_o    = 1'b1;
        bus.c_m_address_o = {tag, idx};
        upd_way           = victim_q;
        if (rd_ok) begin
          upd_en  = 1'b1;
          state_d = StFillDone;
        end
      end
      StFillDone: begin
        bus.c_busywait_o = 1'b1;
        state_d          = StIdle;
      end
      StFlushScan: begin
        bus.c_busywait_o = 1'b1;
        if (dirty_q[fidx][fway]) state_d = StFlushWb;
        else if (&fptr_q)        state_d = StIdle;
      end
      StFlushWb: begin
        bus.c_busywait_o     = 1'b1;
        bus.c_m_wr_o         = 1'b1;
        bus.c_m_address_o    = {tag_q[fidx][fway], fidx};
        bus.c_m_write_data_o = data_q[fidx][fway];
        if (wb_ok) state_d = StFlushScan;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= StIdle;
      valid_q      <= '0;
      dirty_q      <= '0;
      victim_q     <= '0;
      fptr_q       <= '0;
      flush_done_q <= 1'b0;
      for (int s = 0; s < Sets; s++) begin
        for (int w = 0; w < Ways; w++) age_q[s][w] <= c_assiotivity'(w);
      end
    end else begin
      state_q      <= state_d;
      flush_done_q <= 1'b0;
      // Accessed way becomes youngest; only ways younger than it age by one.
      if (upd_en) begin
        for (int w = 0; w < Ways; w++) begin
          if (c_assiotivity'(w) == upd_way)            age_q[idx][w] <= '0;
          else if (age_q[idx][w] < age_q[idx][upd_way]) age_q[idx][w] <= age_q[idx][w] + 1'b1;
        end
      end
      if (flush_go) fptr_q <= '0;
      unique case (state_q)
        StIdle: begin
          if (req && hit && bus.c_wr_i) begin
            dirty_q[idx][hit_way] <= 1'b1;
            for (int b = 0; b < Bytes; b++) begin
              if (bus.c_byte_en_i[b])
                data_q[idx][hit_way][off][b*8 +: 8] <= bus.c_write_data_i[b*8 +: 8];
            end
          end else if (req && !hit) begin
            victim_q <= victim;
          end
        end
        StWriteBack: if (wb_ok) dirty_q[idx][victim_q] <= 1'b0;
        StFill: begin
          if (rd_ok) begin
            data_q[idx][victim_q]  <= bus.c_m_read_data_i;
            tag_q[idx][victim_q]   <= tag;
            valid_q[idx][victim_q] <= 1'b1;
            dirty_q[idx][victim_q] <= 1'b0;
          end
        end
        StFlushScan: begin
          if (!dirty_q[fidx][fway]) begin
            fptr_q <= fptr_q + 1'b1;
            if (&fptr_q) flush_done_q <= 1'b1;
          end
        end
        StFlushWb: if (wb_ok) dirty_q[fidx][fway] <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule
